// File: rtl/mcdf_pkg.sv
// -----------------------------------------------------------------------------
// mcdf_pkg
// Shared definitions for the MCDF datapath: formatter FSM state encoding,
// the "no slave granted" arbiter ID and the packet-length decode.
// The arbiter imports the same ID_NONE constant so both ends agree on it.
// -----------------------------------------------------------------------------
package mcdf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ID_REQ   = 3'd1,
        ST_ID_LATCH = 3'd2,
        ST_FILL     = 3'd3,
        ST_REQ      = 3'd4,
        ST_SEND     = 3'd5
    } fmt_state_e;

    localparam logic [1:0] ID_NONE     = 2'd3;
    localparam int         MAX_PKG_LEN = 32;

    // Packet length code to length in words; codes above 3 saturate at 32.
    function automatic logic [5:0] pkglen_decode(input logic [2:0] sel);
        logic [5:0] len;
        case (sel)
            3'd0:    len = 6'd4;
            3'd1:    len = 6'd8;
            3'd2:    len = 6'd16;
            3'd3:    len = 6'd32;
            default: len = 6'd32;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fmt_pkt_buf.sv
// -----------------------------------------------------------------------------
// fmt_pkt_buf
// Packet buffer for the formatter: BUF_DEPTH x DATA_W register array with one
// synchronous write port and one combinational read port. The formatter owns
// the pointers; contents are cleared on reset so no stale data survives.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   we_i, waddr_i     write enable / write address
//   wdata_i           write data
//   raddr_i           read address
//   rdata_o           read data (combinational)
// -----------------------------------------------------------------------------
module fmt_pkt_buf #(
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 32,
    parameter int AW        = $clog2(BUF_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];

    // Storage array: cleared on reset, one word written per enabled cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read port.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/formatter.sv
// -----------------------------------------------------------------------------
// formatter
// Consumer end of the MCDF arbiter interface. Requests a channel ID from the
// arbiter, pulls one packet of words from the granted slave via val/ack into
// a local buffer, then requests the downstream bus and streams the packet with
// start/end framing, channel ID and length.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   a2f_val_i, a2f_id_i,
//   a2f_data_i, a2f_pkglen_sel_i arbiter side: word valid, grant ID, data, length code
//   f2a_id_req_o, f2a_ack_o      arbiter side: re-arbitrate pulse, word accept
//   fmt_grant_i, fmt_req_o       downstream bus request / grant
//   fmt_chid_o, fmt_length_o     packet channel ID and length, valid REQ..SEND
//   fmt_data_o, fmt_start_o,
//   fmt_end_o                    packet stream, valid in SEND only
//   fmt_idle_o                   FSM is in IDLE
// -----------------------------------------------------------------------------
module formatter
    import mcdf_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a2f_val_i,
    input  logic [1:0]        a2f_id_i,
    input  logic [DATA_W-1:0] a2f_data_i,
    input  logic [2:0]        a2f_pkglen_sel_i,
    output logic              f2a_id_req_o,
    output logic              f2a_ack_o,
    input  logic              fmt_grant_i,
    output logic              fmt_req_o,
    output logic [1:0]        fmt_chid_o,
    output logic [5:0]        fmt_length_o,
    output logic [DATA_W-1:0] fmt_data_o,
    output logic              fmt_start_o,
    output logic              fmt_end_o,
    output logic              fmt_idle_o
);

    localparam int AW = $clog2(BUF_DEPTH);

    fmt_state_e        state_q, state_d;
    logic [1:0]        chid_q, chid_d;
    logic [5:0]        len_q, len_d;
    logic [5:0]        wr_cnt_q, wr_cnt_d;
    logic [5:0]        rd_ptr_q, rd_ptr_d;

    logic              buf_we_s;
    logic [DATA_W-1:0] buf_rdata_s;
    logic              id_req_s;
    logic              ack_s;
    logic              req_s;
    logic              send_s;
    logic              start_s;
    logic              end_s;
    logic              idle_s;

    fmt_pkt_buf #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH),
        .AW        (AW)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (buf_we_s),
        .waddr_i (AW'(wr_cnt_q)),
        .wdata_i (a2f_data_i),
        .raddr_i (AW'(rd_ptr_q)),
        .rdata_o (buf_rdata_s)
    );

    // State, latched packet attributes and buffer pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            chid_q   <= 2'd0;
            len_q    <= 6'd0;
            wr_cnt_q <= 6'd0;
            rd_ptr_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            chid_q   <= chid_d;
            len_q    <= len_d;
            wr_cnt_q <= wr_cnt_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Next-state logic and per-state output decode.
    always_comb begin
        state_d  = state_q;
        chid_d   = chid_q;
        len_d    = len_q;
        wr_cnt_d = wr_cnt_q;
        rd_ptr_d = rd_ptr_q;
        buf_we_s = 1'b0;
        id_req_s = 1'b0;
        ack_s    = 1'b0;
        req_s    = 1'b0;
        send_s   = 1'b0;
        start_s  = 1'b0;
        end_s    = 1'b0;
        idle_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle_s  = 1'b1;
                state_d = ST_ID_REQ;
            end
            ST_ID_REQ: begin
                id_req_s = 1'b1;
                state_d  = ST_ID_LATCH;
            end
            ST_ID_LATCH: begin
                // Arbiter result is stable now; capture it for the whole packet.
                chid_d   = a2f_id_i;
                len_d    = pkglen_decode(a2f_pkglen_sel_i);
                wr_cnt_d = 6'd0;
                rd_ptr_d = 6'd0;
                if (a2f_id_i == ID_NONE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                // Ack follows val but is gated once the packet is full.
                if (a2f_val_i && (wr_cnt_q < len_q)) begin
                    ack_s    = 1'b1;
                    buf_we_s = 1'b1;
                    wr_cnt_d = wr_cnt_q + 6'd1;
                    if (wr_cnt_q == (len_q - 6'd1)) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_REQ: begin
                req_s = 1'b1;
                if (fmt_grant_i) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SEND: begin
                send_s   = 1'b1;
                start_s  = (rd_ptr_q == 6'd0);
                end_s    = (rd_ptr_q == (len_q - 6'd1));
                rd_ptr_d = rd_ptr_q + 6'd1;
                if (end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output drive: attributes visible REQ..SEND, stream visible in SEND only.
    always_comb begin
        f2a_id_req_o = id_req_s;
        f2a_ack_o    = ack_s;
        fmt_req_o    = req_s;
        fmt_idle_o   = idle_s;
        fmt_start_o  = start_s;
        fmt_end_o    = end_s;
        if (req_s || send_s) begin
            fmt_chid_o   = chid_q;
            fmt_length_o = len_q;
        end else begin
            fmt_chid_o   = 2'd0;
            fmt_length_o = 6'd0;
        end
        if (send_s) begin
            fmt_data_o = buf_rdata_s;
        end else begin
            fmt_data_o = '0;
        end
    end

endmodule

// File: tb/tb_formatter.sv
// -----------------------------------------------------------------------------
// tb_formatter
// Self-checking bench for formatter: a slave model feeds words over val/ack,
// expected packets come from the slave's word list and the length rule.
// -----------------------------------------------------------------------------
module tb_formatter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        a2f_val_i;
    logic [1:0]  a2f_id_i;
    logic [31:0] a2f_data_i;
    logic [2:0]  a2f_pkglen_sel_i;
    logic        f2a_id_req_o;
    logic        f2a_ack_o;
    logic        fmt_grant_i;
    logic        fmt_req_o;
    logic [1:0]  fmt_chid_o;
    logic [5:0]  fmt_length_o;
    logic [31:0] fmt_data_o;
    logic        fmt_start_o;
    logic        fmt_end_o;
    logic        fmt_idle_o;

    formatter #(.DATA_W(32), .BUF_DEPTH(32)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .a2f_val_i        (a2f_val_i),
        .a2f_id_i         (a2f_id_i),
        .a2f_data_i       (a2f_data_i),
        .a2f_pkglen_sel_i (a2f_pkglen_sel_i),
        .f2a_id_req_o     (f2a_id_req_o),
        .f2a_ack_o        (f2a_ack_o),
        .fmt_grant_i      (fmt_grant_i),
        .fmt_req_o        (fmt_req_o),
        .fmt_chid_o       (fmt_chid_o),
        .fmt_length_o     (fmt_length_o),
        .fmt_data_o       (fmt_data_o),
        .fmt_start_o      (fmt_start_o),
        .fmt_end_o        (fmt_end_o),
        .fmt_idle_o       (fmt_idle_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int id;       // slave granted by the arbiter
        int sel;      // packet length code
        int vmode;    // 0: val always high, 1: toggling, 2: random
        int gd;       // number of cycles fmt_req_o is held before grant
        int noise;    // spurious grant pulses outside REQ
        int chg;      // arbiter id changed to 0 mid-FILL
        int exp_len;  // expected packet length
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int ref_len(input int sel);
        if (sel >= 3) return 32;
        return 4 << sel;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_i);
        while (!fmt_idle_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        chk("wait_idle", {63'd0, fmt_idle_o}, 64'd1);
    endtask

    task automatic run_pkt(input vec_t v);
        logic [31:0] words [64];
        int sidx, acks, req_cyc, out_idx, c;
        int first_ack, last_ack, first_req, last_req, start_cyc, end_cyc, idreq_cyc, idreq_n;
        bit in_send, done;
        for (int i = 0; i < 64; i++) words[i] = $urandom;
        sidx = 0; acks = 0; req_cyc = 0; out_idx = 0; c = 0;
        first_ack = -1; last_ack = -1; first_req = -1; last_req = -1;
        start_cyc = -1; end_cyc = -1; idreq_cyc = -1; idreq_n = 0;
        in_send = 1'b0; done = 1'b0;
        wait_idle();
        a2f_id_i         = v.id[1:0];
        a2f_pkglen_sel_i = v.sel[2:0];
        while (!done && c < 400) begin
            @(negedge clk_i);
            c++;
            if (f2a_id_req_o) begin
                idreq_cyc = c;
                idreq_n++;
            end
            if (fmt_start_o) begin
                chk("start_once", 64'(out_idx), 64'd0);
                in_send   = 1'b1;
                start_cyc = c;
            end
            if (fmt_req_o) begin
                req_cyc++;
                if (first_req < 0) first_req = c;
                last_req = c;
                chk("req_in_send", {63'd0, in_send}, 64'd0);
            end
            if (fmt_req_o || in_send) begin
                chk("chid", 64'(fmt_chid_o), 64'(v.id));
                chk("length", 64'(fmt_length_o), 64'(v.exp_len));
            end else begin
                chk("chid_zero", 64'(fmt_chid_o), 64'd0);
                chk("length_zero", 64'(fmt_length_o), 64'd0);
            end
            if (in_send) begin
                chk("data", 64'(fmt_data_o), 64'(words[out_idx]));
                chk("end_flag", {63'd0, fmt_end_o}, {63'd0, out_idx == v.exp_len - 1});
                if (fmt_end_o) begin
                    done    = 1'b1;
                    end_cyc = c;
                end
                out_idx++;
                if (out_idx >= v.exp_len) done = 1'b1;
            end else begin
                chk("data_zero", 64'(fmt_data_o), 64'd0);
                chk("end_zero", {63'd0, fmt_end_o}, 64'd0);
            end
            // drive the slave and downstream for the coming edge
            if (v.chg != 0 && acks == 2) a2f_id_i = 2'd0;
            case (v.vmode)
                0:       a2f_val_i = 1'b1;
                1:       a2f_val_i = c[0];
                default: a2f_val_i = 1'($urandom_range(0, 1));
            endcase
            a2f_data_i = words[(sidx < 64) ? sidx : 63];
            if (fmt_req_o) fmt_grant_i = (req_cyc >= v.gd);
            else if (v.noise != 0) fmt_grant_i = 1'($urandom_range(0, 1));
            else fmt_grant_i = 1'b0;
            #1;
            chk("ack_without_val", {63'd0, f2a_ack_o & ~a2f_val_i}, 64'd0);
            if (f2a_ack_o && a2f_val_i) begin
                if (first_ack < 0) first_ack = c;
                last_ack = c;
                acks++;
                sidx++;
            end
        end
        a2f_val_i   = 1'b0;
        fmt_grant_i = 1'b0;
        a2f_id_i    = 2'd3;
        chk("pkt_done", {63'd0, done}, 64'd1);
        chk("ack_count", 64'(acks), 64'(v.exp_len));
        chk("out_count", 64'(out_idx), 64'(v.exp_len));
        chk("req_cycles", 64'(req_cyc), 64'(v.gd));
        chk("idreq_count", 64'(idreq_n), 64'd1);
        chk("ack_to_req", 64'(first_req - last_ack), 64'd1);
        chk("grant_to_start", 64'(start_cyc - last_req), 64'd1);
        if (v.vmode == 0) begin
            chk("idreq_to_ack", 64'(first_ack - idreq_cyc), 64'd2);
            if (v.gd == 1) chk("pkt_cycles", 64'(end_cyc - idreq_cyc + 1), 64'(2 * v.exp_len + 3));
        end
        if (v.vmode == 1) chk("toggle_span", 64'(last_ack - first_ack + 1), 64'(2 * v.exp_len - 1));
    endtask

    task automatic reset_mid_fill();
        int acks, n;
        acks = 0; n = 0;
        wait_idle();
        a2f_id_i         = 2'd1;
        a2f_pkglen_sel_i = 3'd1;
        while (acks < 3 && n < 50) begin
            @(negedge clk_i);
            n++;
            a2f_val_i  = 1'b1;
            a2f_data_i = $urandom;
            #1;
            if (f2a_ack_o && a2f_val_i) acks++;
        end
        chk("mr_acks", 64'(acks), 64'd3);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("mr_idle", {63'd0, fmt_idle_o}, 64'd1);
        chk("mr_ack", {63'd0, f2a_ack_o}, 64'd0);
        chk("mr_outs", {fmt_req_o, f2a_id_req_o, fmt_start_o, fmt_end_o, fmt_chid_o, fmt_length_o, fmt_data_o},
            64'd0);
        @(negedge clk_i);
        a2f_val_i = 1'b0;
        a2f_id_i  = 2'd3;
        rst_i     = 1'b0;
    endtask

    initial begin
        vec_t tbl [8];
        vec_t v;
        int prev, nreq;

        rst_i = 1'b1; a2f_val_i = 1'b0; a2f_id_i = 2'd3; a2f_data_i = 32'd0;
        a2f_pkglen_sel_i = 3'd0; fmt_grant_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_idle", {63'd0, fmt_idle_o}, 64'd1);
        chk("rst_outs", {fmt_req_o, f2a_ack_o, f2a_id_req_o, fmt_start_o, fmt_end_o, fmt_chid_o,
                         fmt_length_o, fmt_data_o}, 64'd0);

        // no slave available: id_req pulses every 3 cycles, never an ack or req
        rst_i = 1'b0;
        a2f_val_i = 1'b1;
        prev = -1; nreq = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_i);
            chk("none_req", {63'd0, fmt_req_o}, 64'd0);
            #1;
            chk("none_ack", {63'd0, f2a_ack_o}, 64'd0);
            if (f2a_id_req_o) begin
                if (prev >= 0) chk("idreq_period", 64'(c - prev), 64'd3);
                prev = c;
                nreq++;
            end
        end
        chk("idreq_pulses", 64'(nreq), 64'd4);
        a2f_val_i = 1'b0;

        //          id sel vm gd nz chg len
        tbl[0] = '{1, 0, 0, 3, 0, 0, 4};
        tbl[1] = '{2, 3, 1, 1, 0, 0, 32};
        tbl[2] = '{0, 5, 0, 1, 0, 0, 32};
        tbl[3] = '{1, 2, 0, 10, 0, 0, 16};
        tbl[4] = '{2, 1, 2, 2, 1, 1, 8};
        tbl[5] = '{0, 7, 2, 2, 0, 0, 32};
        tbl[6] = '{1, 4, 0, 1, 1, 0, 32};
        tbl[7] = '{2, 1, 0, 1, 0, 1, 8};
        for (int i = 0; i < 8; i++) run_pkt(tbl[i]);

        reset_mid_fill();
        v = '{2, 1, 0, 2, 0, 0, 8};
        run_pkt(v);

        for (int i = 0; i < 8; i++) begin
            v.id      = int'($urandom_range(0, 2));
            v.sel     = int'($urandom_range(0, 7));
            v.vmode   = int'($urandom_range(0, 2));
            v.gd      = int'($urandom_range(1, 5));
            v.noise   = int'($urandom_range(0, 1));
            v.chg     = int'($urandom_range(0, 1));
            v.exp_len = ref_len(v.sel);
            run_pkt(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
